// File: rtl/lmt_timestamp_unit_if.sv
// Bus bundle for lmt_timestamp_unit: monitor inputs, register read port and status outputs.
interface lmt_timestamp_unit_if;
    logic        upLMT;
    logic        mon_reset;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        lmt_commit;
    logic        lmt_valid;
    logic        ts_ovf;

    modport master (
        output upLMT, mon_reset, rd_en, rd_addr,
        input  rd_data, lmt_commit, lmt_valid, ts_ovf
    );

    modport slave (
        input  upLMT, mon_reset, rd_en, rd_addr,
        output rd_data, lmt_commit, lmt_valid, ts_ovf
    );
endinterface

// File: rtl/lmt_timestamp_unit.sv
// Prescaled timestamp plus start/commit capture of attested-region modification windows.
// Optional macro LMT_TS_SATURATE_EN: timestamp saturates and raises a sticky ts_ovf.
module lmt_timestamp_unit #(
    parameter int unsigned TS_WIDTH  = 32,
    parameter logic [15:0] PRESCALE  = 16'd1000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lmt_timestamp_unit_if.slave  bus
);

    localparam int unsigned RW = (TS_WIDTH < 32) ? TS_WIDTH : 32;

    typedef enum logic [1:0] {IDLE, MODIFY, KILLED, COMMIT} state_t;

    state_t                 state, state_nxt;
    logic [15:0]            presc;
    logic                   tick;
    logic [TS_WIDTH-1:0]    ts;
    logic [TS_WIDTH-1:0]    lmt_start;
    logic [TS_WIDTH-1:0]    lmt_end;
    logic [CNT_WIDTH-1:0]   mod_cnt;
    logic                   up_d;
    logic                   rise;
    logic                   fall;
    logic                   cap_start;
    logic                   cap_end;
    logic                   busy;
    logic                   commit;
    logic                   valid_q;
    logic                   ovf;
    logic [15:0]            snap;
    logic [15:0]            rd_q;
    logic [15:0]            rd_mux;
    logic [31:0]            ts32;
    logic [31:0]            start32;
    logic [31:0]            end32;

    assign tick = (presc == PRESCALE - 16'd1);
    assign rise = bus.upLMT & ~up_d;
    assign fall = ~bus.upLMT & up_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            up_d  <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 16'd1;
            up_d  <= bus.upLMT;
        end
    end

`ifdef LMT_TS_SATURATE_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts    <= '0;
            ovf_q <= 1'b0;
        end else if (tick) begin
            if (ts == '1)
                ovf_q <= 1'b1;
            else
                ts <= ts + TS_WIDTH'(1);
        end
    end

    assign ovf = ovf_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ts <= '0;
        else if (tick)
            ts <= ts + TS_WIDTH'(1);
    end

    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // COMMIT behaves like IDLE for a coincident rise so back-to-back windows lose no edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = MODIFY;
            MODIFY:  begin
                if (bus.mon_reset)
                    state_nxt = KILLED;
                else if (fall)
                    state_nxt = COMMIT;
            end
            KILLED:  if (fall) state_nxt = COMMIT;
            COMMIT:  state_nxt = rise ? MODIFY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        commit    = (state == COMMIT);
        busy      = (state == MODIFY) || (state == KILLED);
        cap_start = ((state == IDLE) || (state == COMMIT)) && rise;
        cap_end   = ((state == MODIFY) && !bus.mon_reset && fall) ||
                    ((state == KILLED) && fall);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lmt_start <= '0;
            lmt_end   <= '0;
            mod_cnt   <= '0;
            valid_q   <= 1'b0;
        end else begin
            if (cap_start) begin
                lmt_start <= ts;
                if (mod_cnt != '1)
                    mod_cnt <= mod_cnt + CNT_WIDTH'(1);
            end
            if (cap_end)
                lmt_end <= ts;
            if (commit)
                valid_q <= 1'b1;
        end
    end

    assign ts32    = 32'(ts[RW-1:0]);
    assign start32 = 32'(lmt_start[RW-1:0]);
    assign end32   = 32'(lmt_end[RW-1:0]);

    always_comb begin
        rd_mux = '0;
        case (bus.rd_addr)
            3'd0: rd_mux = start32[15:0];
            3'd1: rd_mux = start32[31:16];
            3'd2: rd_mux = end32[15:0];
            3'd3: rd_mux = end32[31:16];
            3'd4: rd_mux = ts32[15:0];
            3'd5: rd_mux = snap;
            3'd6: rd_mux = 16'(mod_cnt);
            3'd7: rd_mux = {13'b0, ovf, valid_q, busy};
            default: rd_mux = '0;
        endcase
    end

    // Reading the low timestamp half freezes the high half so a 4-then-5 read is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            snap <= '0;
        end else if (bus.rd_en) begin
            rd_q <= rd_mux;
            if (bus.rd_addr == 3'd4)
                snap <= ts32[31:16];
        end
    end

    assign bus.rd_data    = rd_q;
    assign bus.lmt_commit = commit;
    assign bus.lmt_valid  = valid_q;
    assign bus.ts_ovf     = ovf;

endmodule

// File: tb/tb_lmt_timestamp_unit.sv
// Directed bench for lmt_timestamp_unit: three instances (PRESCALE 4, PRESCALE 1, 16-bit ts).
module tb_lmt_timestamp_unit;

    logic clk = 1'b0;
    logic rst_n_p4  = 1'b0;
    logic rst_n_p1  = 1'b0;
    logic rst_n_w16 = 1'b0;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc    = 0;
    int unsigned cyc_p1 = 0;
    int unsigned ncommit_p4 = 0;
    int unsigned ncommit_p1 = 0;

    always #5 clk = ~clk;

    lmt_timestamp_unit_if bus_p4 ();
    lmt_timestamp_unit_if bus_p1 ();
    lmt_timestamp_unit_if bus_w16 ();

    lmt_timestamp_unit #(.TS_WIDTH(32), .PRESCALE(16'd4), .CNT_WIDTH(16)) u_p4 (
        .clk(clk), .rst_n(rst_n_p4), .bus(bus_p4));
    lmt_timestamp_unit #(.TS_WIDTH(32), .PRESCALE(16'd1), .CNT_WIDTH(16)) u_p1 (
        .clk(clk), .rst_n(rst_n_p1), .bus(bus_p1));
    lmt_timestamp_unit #(.TS_WIDTH(16), .PRESCALE(16'd1), .CNT_WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n_w16), .bus(bus_w16));

    always @(posedge clk) if (rst_n_p4) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n_p1) begin
        if (!rst_n_p1) cyc_p1 <= 0;
        else           cyc_p1 <= cyc_p1 + 1;
    end

    always @(negedge clk) begin
        if (bus_p4.lmt_commit) ncommit_p4 <= ncommit_p4 + 1;
        if (bus_p1.lmt_commit) ncommit_p1 <= ncommit_p1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int unsigned which, input logic [2:0] a, output logic [15:0] d);
        case (which)
            0: begin bus_p4.rd_en  = 1'b1; bus_p4.rd_addr  = a; end
            1: begin bus_p1.rd_en  = 1'b1; bus_p1.rd_addr  = a; end
            default: begin bus_w16.rd_en = 1'b1; bus_w16.rd_addr = a; end
        endcase
        @(negedge clk);
        case (which)
            0: d = bus_p4.rd_data;
            1: d = bus_p1.rd_data;
            default: d = bus_w16.rd_data;
        endcase
        bus_p4.rd_en = 1'b0; bus_p1.rd_en = 1'b0; bus_w16.rd_en = 1'b0;
    endtask

    task automatic rd_chk(input int unsigned which, input logic [2:0] a,
                          input logic [15:0] exp, input string tag);
        logic [15:0] d;
        rd(which, a, d);
        chk(tag, 32'(d), 32'(exp));
    endtask

    task automatic wait_p1(input int unsigned target);
        while (cyc_p1 < target) @(negedge clk);
        chk("wait_p1_align", cyc_p1, target);
    endtask

    initial begin
        bus_p4.upLMT = 0; bus_p4.mon_reset = 0; bus_p4.rd_en = 0; bus_p4.rd_addr = '0;
        bus_p1.upLMT = 0; bus_p1.mon_reset = 0; bus_p1.rd_en = 0; bus_p1.rd_addr = '0;
        bus_w16.upLMT = 0; bus_w16.mon_reset = 0; bus_w16.rd_en = 0; bus_w16.rd_addr = '0;

        repeat (2) @(negedge clk);
        chk("rst_rd_data",    32'(bus_p1.rd_data), 0);
        chk("rst_lmt_valid",  32'(bus_p1.lmt_valid), 0);
        chk("rst_lmt_commit", 32'(bus_p1.lmt_commit), 0);
        chk("rst_ts_ovf",     32'(bus_w16.ts_ovf), 0);
        rst_n_p4 = 1'b1; rst_n_p1 = 1'b1; rst_n_w16 = 1'b1;

        // idle with PRESCALE=4: 40 cycles -> ts 10
        while (cyc < 40) @(negedge clk);
        rd_chk(0, 3'd4, 16'd10, "idle_ts");
        rd_chk(0, 3'd6, 16'd0,  "idle_modcnt");
        rd_chk(0, 3'd7, 16'd0,  "idle_status");

        // single window 100..150
        wait_p1(100); bus_p1.upLMT = 1'b1;
        @(negedge clk);
        rd_chk(1, 3'd7, 16'h1, "win_status_busy");
        wait_p1(150); bus_p1.upLMT = 1'b0;
        wait_p1(152);
        chk("win_commits", ncommit_p1, 1);
        chk("win_valid", 32'(bus_p1.lmt_valid), 1);
        rd_chk(1, 3'd0, 16'd100, "win_start_lo");
        rd_chk(1, 3'd1, 16'd0,   "win_start_hi");
        rd_chk(1, 3'd2, 16'd150, "win_end_lo");
        rd_chk(1, 3'd3, 16'd0,   "win_end_hi");
        rd_chk(1, 3'd6, 16'd1,   "win_modcnt");
        rd_chk(1, 3'd7, 16'h2,   "win_status");
        @(negedge clk);
        chk("rd_hold", 32'(bus_p1.rd_data), 32'h2);

        // kill path: rise 200, mon_reset 250..254, fall 300
        wait_p1(200); bus_p1.upLMT = 1'b1;
        wait_p1(250); bus_p1.mon_reset = 1'b1;
        wait_p1(255); bus_p1.mon_reset = 1'b0;
        rd_chk(1, 3'd7, 16'h3, "kill_status_busy");
        wait_p1(300); bus_p1.upLMT = 1'b0;
        wait_p1(302);
        chk("kill_commits", ncommit_p1, 2);
        rd_chk(1, 3'd0, 16'd200, "kill_start");
        rd_chk(1, 3'd2, 16'd300, "kill_end");
        rd_chk(1, 3'd6, 16'd2,   "kill_modcnt");

        // back-to-back: fall at 450, re-rise on the COMMIT cycle, fall at 500
        wait_p1(400); bus_p1.upLMT = 1'b1;
        wait_p1(450); bus_p1.upLMT = 1'b0;
        wait_p1(451);
        chk("b2b_commit_pulse", 32'(bus_p1.lmt_commit), 1);
        bus_p1.upLMT = 1'b1;
        wait_p1(500); bus_p1.upLMT = 1'b0;
        wait_p1(502);
        chk("b2b_commits", ncommit_p1, 4);
        rd_chk(1, 3'd0, 16'd451, "b2b_start");
        rd_chk(1, 3'd2, 16'd500, "b2b_end");
        rd_chk(1, 3'd6, 16'd4,   "b2b_modcnt");

        // snapshot coherence across the 0xFFFF -> 0x10000 carry
        wait_p1(65535);
        rd_chk(1, 3'd4, 16'hFFFF, "snap_lo");
        rd_chk(1, 3'd5, 16'h0000, "snap_hi");
        rd_chk(1, 3'd5, 16'h0000, "snap_hi_held");
        rd_chk(1, 3'd4, 16'h0002, "snap2_lo");
        rd_chk(1, 3'd5, 16'h0001, "snap2_hi");

        // 16-bit timestamp after 70000 cycles
        while (cyc < 70000) @(negedge clk);
`ifdef LMT_TS_SATURATE_EN
        rd_chk(2, 3'd4, 16'hFFFF, "w16_ts");
        rd_chk(2, 3'd7, 16'h4,    "w16_status");
        chk("w16_ovf", 32'(bus_w16.ts_ovf), 1);
`else
        rd_chk(2, 3'd4, 16'd4464, "w16_ts");
        rd_chk(2, 3'd7, 16'h0,    "w16_status");
        chk("w16_ovf", 32'(bus_w16.ts_ovf), 0);
`endif

        // async reset while in MODIFY
        bus_p1.upLMT = 1'b1;
        @(negedge clk);
        rd_chk(1, 3'd7, 16'h3, "arst_pre_status");
        #2 rst_n_p1 = 1'b0;
        #1;
        chk("arst_rd_data", 32'(bus_p1.rd_data), 0);
        chk("arst_valid",   32'(bus_p1.lmt_valid), 0);
        chk("arst_commit",  32'(bus_p1.lmt_commit), 0);
        bus_p1.upLMT = 1'b0;
        @(negedge clk);
        rst_n_p1 = 1'b1;
        rd_chk(1, 3'd7, 16'h0, "arst_status");
        rd_chk(1, 3'd6, 16'h0, "arst_modcnt");
        rd_chk(1, 3'd4, 16'd2, "arst_ts");

        chk("p4_no_commit", ncommit_p4, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
